// File: rtl/aes_byte_scanner_if.sv
// Block handshake and byte-display bus between the AES result source and the scanner.
// The scanner drives the display side; the source drives the block and the hold request.
interface aes_byte_scanner_if;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_ready;
  logic         hold;
  logic [7:0]   byte_out;
  logic [3:0]   byte_idx;
  logic         byte_valid;
  logic         done;
  logic         ovf;

  modport slave (
    input  blk_valid, blk_data, hold,
    output blk_ready, byte_out, byte_idx, byte_valid, done, ovf
  );

  modport master (
    output blk_valid, blk_data, hold,
    input  blk_ready, byte_out, byte_idx, byte_valid, done, ovf
  );
endinterface

// File: rtl/aes_byte_scanner.sv
// Latches one 128-bit AES block and shows it a byte at a time, MSB byte first,
// holding each byte for DWELL clocks, for the BCD / seven-segment display path.
module aes_byte_scanner #(
  parameter int unsigned DWELL = 4,
  parameter bit          LOOP  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_byte_scanner_if.slave  bus
);

  localparam int unsigned CW = $clog2(DWELL + 1);

  typedef enum logic [0:0] {IDLE, SHOW} state_e;

  state_e         state_q, state_d;
  logic [127:0]   data_q, data_d;
  logic [3:0]     idx_q, idx_d;
  logic [CW-1:0]  dwell_q, dwell_d;
  logic           ready_q, ready_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic [127:0]   shifted;

  logic accept;
  logic last_dwell;

  assign accept     = bus.blk_valid && ready_q;
  assign last_dwell = (dwell_q == CW'(DWELL - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      dwell_q <= '0;
      ready_q <= 1'b1;
      byte_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      ready_q <= ready_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: dwell/idx stepping, end of scan, accept (accept overrides end of scan)
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    ready_d = ready_q;
    valid_d = valid_q;
    byte_d  = byte_q;
    shifted = '0;

    if (bus.blk_valid && !ready_q) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
      end
      SHOW: begin
        if (!bus.hold) begin
          if (last_dwell) begin
            dwell_d = '0;
            if (idx_q != 4'd15) begin
              idx_d = idx_q + 4'd1;
            end else begin
              done_d = 1'b1;
              if (LOOP) begin
                idx_d = '0;
              end else begin
                state_d = IDLE;
              end
            end
          end else begin
            dwell_d = dwell_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      data_d  = bus.blk_data;
      idx_d   = '0;
      dwell_d = '0;
      state_d = SHOW;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
    end

    ready_d = LOOP ? 1'b1 : (state_d == IDLE);
    valid_d = (state_d == SHOW);
    // In IDLE data and idx are unchanged, so the shown byte naturally holds
    shifted = data_d << {idx_d, 3'b000};
    byte_d  = shifted[127:120];
  end

  assign bus.blk_ready  = ready_q;
  assign bus.byte_out   = byte_q;
  assign bus.byte_idx   = idx_q;
  assign bus.byte_valid = valid_q;
  assign bus.done       = done_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_aes_byte_scanner.sv
// Self-checking bench: two scanners (LOOP=0/DWELL=4 and LOOP=1/DWELL=1) against an
// elapsed-time reference model, plus directed literal checks from the test plan.
module tb_aes_byte_scanner;

  localparam int D0 = 4;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_byte_scanner_if if0();
  aes_byte_scanner_if if1();

  aes_byte_scanner #(.DWELL(D0), .LOOP(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  aes_byte_scanner #(.DWELL(D1), .LOOP(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct {
    bit           active;
    logic [127:0] blk;
    int           elapsed;
    bit           ready;
    bit           done;
    bit           ovf;
    logic [7:0]   bo;
    logic [3:0]   idx;
  } mdl_t;

  mdl_t m0, m1;
  bit   armed = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   e;

  // Model: position = count of non-held clocks since accept; byte index = position / dwell
  function automatic mdl_t step(mdl_t m, int dw, bit lp, bit rst, bit v, logic [127:0] d, bit h);
    mdl_t n = m;
    logic [127:0] t;
    if (!rst) begin
      n.active = 0; n.blk = '0; n.elapsed = 0; n.ready = 1;
      n.done = 0; n.ovf = 0; n.bo = '0; n.idx = '0;
      return n;
    end
    n.done = 0;
    if (v && !m.ready) n.ovf = 1;
    if (m.active && !h) begin
      n.elapsed = m.elapsed + 1;
      if (n.elapsed == 16 * dw) begin
        n.done = 1;
        n.elapsed = 0;
        if (!lp) n.active = 0;
      end
    end
    if (v && m.ready) begin
      n.blk = d; n.active = 1; n.elapsed = 0; n.ovf = 0; n.done = 0;
    end
    n.ready = lp ? 1'b1 : !n.active;
    if (n.active) begin
      n.idx = 4'(n.elapsed / dw);
      t = n.blk >> (8 * (15 - int'(n.idx)));
      n.bo = t[7:0];
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  always @(posedge clk) begin
    if (!rst_n) armed = 1'b1;
    m0 = step(m0, D0, 1'b0, rst_n, if0.blk_valid, if0.blk_data, if0.hold);
    m1 = step(m1, D1, 1'b1, rst_n, if1.blk_valid, if1.blk_data, if1.hold);
  end

  // Cycle-by-cycle comparison of both scanners against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("u0.blk_ready",  32'(if0.blk_ready),  32'(m0.ready));
      chk("u0.byte_out",   32'(if0.byte_out),   32'(m0.bo));
      chk("u0.byte_idx",   32'(if0.byte_idx),   32'(m0.idx));
      chk("u0.byte_valid", 32'(if0.byte_valid), 32'(m0.active));
      chk("u0.done",       32'(if0.done),       32'(m0.done));
      chk("u0.ovf",        32'(if0.ovf),        32'(m0.ovf));
      chk("u1.blk_ready",  32'(if1.blk_ready),  32'(m1.ready));
      chk("u1.byte_out",   32'(if1.byte_out),   32'(m1.bo));
      chk("u1.byte_idx",   32'(if1.byte_idx),   32'(m1.idx));
      chk("u1.byte_valid", 32'(if1.byte_valid), 32'(m1.active));
      chk("u1.done",       32'(if1.done),       32'(m1.done));
      chk("u1.ovf",        32'(if1.ovf),        32'(m1.ovf));
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] blk_a, blk_b, blk_c, blk_d;
  int           ndone;

  initial begin
    blk_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    blk_b = 128'h00112233445566778899aabbccddeeff;
    blk_c = rnd128();
    blk_d = rnd128();
    e = 0;

    // Reset with blk_valid asserted: no accept
    rst_n = 1'b0;
    if0.blk_valid = 1'b1; if0.blk_data = rnd128(); if0.hold = 1'b0;
    if1.blk_valid = 1'b1; if1.blk_data = rnd128(); if1.hold = 1'b0;
    tick(); tick();
    chk("rst_ready",  32'(if0.blk_ready), 32'd1);
    chk("rst_valid",  32'(if0.byte_valid), 32'd0);
    chk("rst_byte",   32'(if0.byte_out), 32'h00);
    chk("rst_idx",    32'(if0.byte_idx), 32'd0);
    chk("rst_done",   32'(if0.done), 32'd0);
    chk("rst_ovf",    32'(if0.ovf), 32'd0);
    chk("rst_valid1", 32'(if1.byte_valid), 32'd0);
    rst_n = 1'b1;
    if0.blk_valid = 1'b0;
    if1.blk_valid = 1'b0;
    tick();

    // Single scan, no hold
    if0.blk_valid = 1'b1; if0.blk_data = blk_a;
    tick(); e = 0;
    if0.blk_valid = 1'b0;
    chk("s1_b0",    32'(if0.byte_out), 32'h69);
    chk("s1_idx0",  32'(if0.byte_idx), 32'd0);
    chk("s1_valid", 32'(if0.byte_valid), 32'd1);
    chk("s1_ready", 32'(if0.blk_ready), 32'd0);
    repeat (4) tick();
    chk("s1_b1", 32'(if0.byte_out), 32'hc4);
    repeat (56) tick();
    chk("s1_b15",   32'(if0.byte_out), 32'h5a);
    chk("s1_idx15", 32'(if0.byte_idx), 32'd15);
    repeat (3) tick();
    chk("s1_done_early", 32'(if0.done), 32'd0);
    tick();
    chk("s1_done",      32'(if0.done), 32'd1);
    chk("s1_end_valid", 32'(if0.byte_valid), 32'd0);
    chk("s1_end_ready", 32'(if0.blk_ready), 32'd1);
    chk("s1_end_byte",  32'(if0.byte_out), 32'h5a);
    tick();
    chk("s1_done_width", 32'(if0.done), 32'd0);

    // Hold during byte 3 plus an overflow pulse mid-scan
    if0.blk_valid = 1'b1; if0.blk_data = blk_a;
    tick(); e = 0;
    if0.blk_valid = 1'b0;
    repeat (12) tick();
    chk("s2_idx3", 32'(if0.byte_idx), 32'd3);
    chk("s2_b3",   32'(if0.byte_out), 32'hd8);
    if0.hold = 1'b1;
    repeat (5) tick();
    if0.hold = 1'b0;
    repeat (3) tick();
    chk("s2_held", 32'(if0.byte_idx), 32'd3);
    tick();
    chk("s2_idx4", 32'(if0.byte_idx), 32'd4);
    chk("s2_b4",   32'(if0.byte_out), 32'h6a);
    repeat (5) tick();
    if0.blk_valid = 1'b1; if0.blk_data = '0;
    tick();
    if0.blk_valid = 1'b0;
    chk("s2_ovf",  32'(if0.ovf), 32'd1);
    chk("s2_idx5", 32'(if0.byte_idx), 32'd5);
    chk("s2_b5",   32'(if0.byte_out), 32'h7b);
    while (!if0.done && e < 200) tick();
    chk("s2_done_edge", 32'(e), 32'd69);
    chk("s2_ovf_sticky", 32'(if0.ovf), 32'd1);

    // New block after overflow clears ovf
    if0.blk_valid = 1'b1; if0.blk_data = blk_b;
    tick(); e = 0;
    if0.blk_valid = 1'b0;
    chk("s3_ovf", 32'(if0.ovf), 32'd0);
    chk("s3_b0",  32'(if0.byte_out), 32'h00);
    tick();
    while (!if0.done && e < 200) tick();
    chk("s3_done_edge", 32'(e), 32'd64);

    // Loop mode, DWELL=1: wrap then collision on end edge
    if1.blk_valid = 1'b1; if1.blk_data = blk_c;
    tick(); e = 0;
    if1.blk_valid = 1'b0;
    chk("l_b0", 32'(if1.byte_out), 32'(blk_c[127:120]));
    while (!if1.done && e < 100) tick();
    chk("l_done_edge", 32'(e), 32'd16);
    chk("l_wrap_idx",  32'(if1.byte_idx), 32'd0);
    chk("l_wrap_byte", 32'(if1.byte_out), 32'(blk_c[127:120]));
    repeat (15) tick();
    chk("l_idx15", 32'(if1.byte_idx), 32'd15);
    if1.blk_valid = 1'b1; if1.blk_data = blk_d;
    tick();
    if1.blk_valid = 1'b0;
    chk("l_coll_done", 32'(if1.done), 32'd0);
    chk("l_coll_idx",  32'(if1.byte_idx), 32'd0);
    chk("l_coll_byte", 32'(if1.byte_out), 32'(blk_d[127:120]));
    tick();
    chk("l_coll_idx1", 32'(if1.byte_idx), 32'd1);
    chk("l_coll_done2", 32'(if1.done), 32'd0);

    // Randomized traffic, compared every cycle against the model
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom % 400) != 0;
      if0.blk_valid = ($urandom % 12) == 0;
      if0.blk_data  = rnd128();
      if0.hold      = ($urandom % 4) == 0;
      if1.blk_valid = ($urandom % 12) == 0;
      if1.blk_data  = rnd128();
      if1.hold      = ($urandom % 4) == 0;
      tick();
    end
    rst_n = 1'b1;
    if0.blk_valid = 1'b0; if0.hold = 1'b0;
    if1.blk_valid = 1'b0; if1.hold = 1'b0;
    repeat (80) tick();

    // Reset mid-scan at byte 7
    if0.blk_valid = 1'b1; if0.blk_data = blk_a;
    tick(); e = 0;
    if0.blk_valid = 1'b0;
    repeat (28) tick();
    chk("r_idx7", 32'(if0.byte_idx), 32'd7);
    rst_n = 1'b0;
    tick();
    chk("r_valid", 32'(if0.byte_valid), 32'd0);
    chk("r_idx",   32'(if0.byte_idx), 32'd0);
    chk("r_ready", 32'(if0.blk_ready), 32'd1);
    chk("r_done",  32'(if0.done), 32'd0);
    chk("r_byte",  32'(if0.byte_out), 32'h00);
    rst_n = 1'b1;
    ndone = 0;
    repeat (60) begin
      tick();
      if (if0.done) ndone++;
    end
    chk("r_no_done", 32'(ndone), 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_byte_scanner.md
# aes_byte_scanner

Downstream display stage for the AES top level. Captures one 128-bit cipher/decipher result through a valid/ready handshake and presents it one byte at a time, MSB byte first, holding each byte for a programmable number of clocks. Its byte output feeds the existing binary-to-BCD encoder and seven-segment decoder path, so all 16 bytes of a block can be shown on HEX0..HEX2 instead of only bits [7:0].

## Interface
- DWELL, default 4: clocks each byte is held, must be ≥1. Synthesis on the board overrides it, e.g. 50_000_000.
- LOOP, default 0: 0 = scan once then idle; 1 = rescan the same block until a new one is accepted.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- blk_valid  in  1  upstream has a block on blk_data.
- blk_data  in  128  AES result block; byte 0 = blk_data[127:120].
- blk_ready  out  1  scanner can accept a block this cycle.
- hold  in  1  freeze the current byte; the dwell counter does not advance.
- byte_out  out  8  currently displayed byte.
- byte_idx  out  4  index of byte_out, 0..15.
- byte_valid  out  1  byte_out/byte_idx are meaningful.
- done  out  1  one-cycle pulse at the end of a full 16-byte scan.
- ovf  out  1  sticky: blk_valid was asserted while blk_ready=0.

## Operation
- States: IDLE, SHOW.
- Accept happens on any clock edge with blk_valid=1 and blk_ready=1. On accept:
  - latch blk_data;
  - set idx=0 and dwell=0;
  - enter SHOW;
  - clear ovf.
- blk_ready is registered:
  - LOOP=0: 1 in IDLE, 0 in SHOW.
  - LOOP=1: always 1 after reset; an accept in SHOW restarts the scan at idx 0 with the new block.
- In SHOW:
  - byte_valid=1 and byte_out = latched[127-8*idx -: 8].
  - dwell increments by 1 each clock with hold=0. With hold=1, dwell and idx are frozen.
  - When dwell==DWELL-1, hold=0 and idx<15: idx+1, dwell=0.
  - When dwell==DWELL-1, hold=0 and idx==15: done=1 for one cycle.
    - LOOP=0: go to IDLE, byte_valid=0.
    - LOOP=1: idx=0, dwell=0, stay in SHOW.
- Simultaneous accept and end-of-scan (LOOP=1 only): the accept wins. The new block starts at idx 0 and done is not pulsed.
- blk_valid while blk_ready=0 sets ovf=1. The request is ignored and the latched block is unchanged.
- In IDLE, byte_out and byte_idx keep their last values and byte_valid=0.
- dwell counter width is $clog2(DWELL+1). No counter wrap occurs because dwell is cleared at DWELL-1.

## Timing
- Reset values, applied at the first rising edge with rst_n=0:
  - byte_out=8'h00, byte_idx=0, byte_valid=0, done=0, ovf=0;
  - blk_ready=1, state IDLE, dwell=0.
- Reset mid-scan discards the latched block. All outputs return to their reset values at that edge.
- Latency with accept at edge k:
  - byte_valid=1, byte_idx=0, byte_out=blk_data[127:120] are visible after edge k.
  - Byte n is displayed from edge k+n·DWELL to k+(n+1)·DWELL.
- End of scan, with no hold:
  - done is high during the cycle after edge k+16·DWELL.
  - LOOP=0: byte_valid falls and blk_ready rises at that same edge. The earliest next accept is edge k+16·DWELL+1.
- Each hold=1 cycle extends the scan by exactly one clock.
- done is always exactly one cycle wide; hold=1 cannot stretch it.
- All outputs are registered; no combinational path from input to output.

## Test plan
- **Reset:** drive rst_n=0 with blk_valid=1 -> all outputs at reset values, no accept.
- **Single scan:** LOOP=0, DWELL=4, accept 128'h69c4e0d86a7b0430d8cdb78070b4c55a at edge k.
  - byte_out sequence is 69,c4,e0,d8,…,c5,5a, each held for 4 clocks.
  - done is a single pulse after edge k+64.
  - byte_valid=0 and blk_ready=1 afterwards.
- **Hold:** during byte_idx=3 (d8), assert hold for 5 cycles -> d8 is shown for 9 clocks and done moves to after edge k+69.
- **Overflow:** LOOP=0, pulse blk_valid with 128'h0 mid-scan.
  - ovf=1 and the scan continues with the original bytes.
  - After done, accept 128'h00112233445566778899aabbccddeeff: ovf=0 and byte_out=00.
- **Loop and collision:** LOOP=1, DWELL=1.
  - Without a new block: done pulses every 16 clocks and byte_idx wraps 15->0.
  - Accept a new block on the idx=15 end edge: done is not pulsed, byte_idx=0 and byte_out is the new block's byte 0.
- **Reset mid-scan:** assert rst_n=0 at byte_idx=7 -> byte_valid=0, byte_idx=0, blk_ready=1 at the next edge, and no done pulse.
